// File: rtl/dual_port_ram_sync_rdw_pkg.sv
// Shared constants for the single-clock true dual-port RAM with clear sequencer.
package dual_port_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Clear-sequencer state encoding
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  typedef logic [0:0] state_t;

endpackage

// File: rtl/dual_port_ram_sync_rdw_if.sv
// Port bundle for dual_port_ram_sync_rdw: two read/write ports plus init/collision status.
interface dual_port_ram_sync_rdw_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);

  logic                  init_req;
  logic                  init_busy;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  collision;

  modport master (
    output init_req, we_a, addr_a, din_a, we_b, addr_b, din_b,
    input  init_busy, dout_a, dout_b, collision
  );

  modport slave (
    input  init_req, we_a, addr_a, din_a, we_b, addr_b, din_b,
    output init_busy, dout_a, dout_b, collision
  );

endinterface

// File: rtl/dual_port_ram_sync_rdw_ram_clear_seq.sv
// Zero-fill sequencer: walks every address once after reset or on init_req.
module ram_clear_seq
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          // Last address written this cycle; counter wraps back to 0
          if (cnt == '1) state <= READY;
        end
        READY: begin
          if (init_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign init_busy = (state == CLEAR);
  assign clr_we    = (state == CLEAR);
  assign clr_addr  = cnt;

endmodule

// File: rtl/dual_port_ram_sync_rdw.sv
// True dual-port synchronous RAM with selectable read-during-write, optional
// output register, A-wins write arbitration and hardware zero-fill.
module dual_port_ram_sync_rdw
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input logic                    clk,
  input logic                    reset_n,
  dual_port_ram_sync_rdw_if.slave bus
);

  localparam int DEPTH       = 1 << ADDR_WIDTH;
  localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .init_req  (bus.init_req),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  logic                  coll_now;
  logic                  wr_a_en;
  logic [ADDR_WIDTH-1:0] wr_a_addr;
  logic [DATA_WIDTH-1:0] wr_a_data;
  logic                  wr_b_en;
  logic [DATA_WIDTH-1:0] rd_a_next;
  logic [DATA_WIDTH-1:0] rd_b_next;

  // Clear writes take over the port A write path; user writes are dropped meanwhile
  assign coll_now  = !init_busy && bus.we_a && bus.we_b && (bus.addr_a == bus.addr_b);
  assign wr_a_en   = clr_we || bus.we_a;
  assign wr_a_addr = clr_we ? clr_addr : bus.addr_a;
  assign wr_a_data = clr_we ? '0 : bus.din_a;
  assign wr_b_en   = !init_busy && bus.we_b && !coll_now;

  always_ff @(posedge clk) begin
    if (wr_b_en) mem[bus.addr_b] <= bus.din_b;
    if (wr_a_en) mem[wr_a_addr]  <= wr_a_data;
  end

  // Write-first on B in a collision returns what was actually stored (din_a)
  assign rd_a_next = (WRITE_FIRST && bus.we_a) ? bus.din_a : mem[bus.addr_a];
  assign rd_b_next = (WRITE_FIRST && bus.we_b) ? (coll_now ? bus.din_a : bus.din_b)
                                               : mem[bus.addr_b];

  logic [DATA_WIDTH-1:0] rd_a_p0, rd_b_p0;
  logic [DATA_WIDTH-1:0] rd_a_p1, rd_b_p1;
  logic                  coll_p0;

  // Stage p0: synchronous array read and collision flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_p0 <= '0;
      rd_b_p0 <= '0;
      coll_p0 <= 1'b0;
    end else if (init_busy) begin
      rd_a_p0 <= '0;
      rd_b_p0 <= '0;
      coll_p0 <= 1'b0;
    end else begin
      rd_a_p0 <= rd_a_next;
      rd_b_p0 <= rd_b_next;
      coll_p0 <= coll_now;
    end
  end

  // Stage p1: optional output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_a_p1 <= '0;
      rd_b_p1 <= '0;
    end else if (init_busy) begin
      rd_a_p1 <= '0;
      rd_b_p1 <= '0;
    end else begin
      rd_a_p1 <= rd_a_p0;
      rd_b_p1 <= rd_b_p0;
    end
  end

  assign bus.init_busy = init_busy;
  assign bus.dout_a    = init_busy ? '0 : ((OUT_REG != 0) ? rd_a_p1 : rd_a_p0);
  assign bus.dout_b    = init_busy ? '0 : ((OUT_REG != 0) ? rd_b_p1 : rd_b_p0);
  assign bus.collision = coll_p0 && !init_busy;

endmodule

// File: tb/tb_dual_port_ram_sync_rdw.sv
// Bench for dual_port_ram_sync_rdw: two instances (read-first/latency 1 and
// write-first/latency 2) share stimulus and are checked against a memory model.
module tb_dual_port_ram_sync_rdw;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dual_port_ram_sync_rdw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
  dual_port_ram_sync_rdw_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

  dual_port_ram_sync_rdw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave));
  dual_port_ram_sync_rdw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave));

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          coll;
  } exp_t;

  typedef struct {
    logic          wa;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          wb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic          ec;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] m [DEPTH];
  vec_t tbl [13];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk8(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input logic ir);
    if0.we_a = wa; if0.addr_a = aa; if0.din_a = da;
    if0.we_b = wb; if0.addr_b = ab; if0.din_b = db; if0.init_req = ir;
    if1.we_a = wa; if1.addr_a = aa; if1.din_a = da;
    if1.we_b = wb; if1.addr_b = ab; if1.din_b = db; if1.init_req = ir;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, ".busy0"}, if0.init_busy, 1'b1);
    chk1({tag, ".busy1"}, if1.init_busy, 1'b1);
    chk8({tag, ".dout_a0"}, if0.dout_a, '0);
    chk8({tag, ".dout_b0"}, if0.dout_b, '0);
    chk8({tag, ".dout_a1"}, if1.dout_a, '0);
    chk8({tag, ".dout_b1"}, if1.dout_b, '0);
    chk1({tag, ".coll0"}, if0.collision, 1'b0);
    chk1({tag, ".coll1"}, if1.collision, 1'b0);
  endtask

  // One READY-state cycle: push model expectations, clock, pop and compare
  task automatic step(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input string tag);
    exp_t e0, e1;
    logic c;
    c = wa && wb && (aa == ab);
    e0.a = m[aa]; e0.b = m[ab]; e0.coll = c;
    e1.a = wa ? da : m[aa];
    e1.b = wb ? (c ? da : db) : m[ab];
    e1.coll = c;
    q0.push_back(e0);
    q1.push_back(e1);
    if (wb && !c) m[ab] = db;
    if (wa) m[aa] = da;
    drive(wa, aa, da, wb, ab, db, 1'b0);
    @(posedge clk); #1;
    e0 = q0.pop_front();
    chk8({tag, ".dout_a0"}, if0.dout_a, e0.a);
    chk8({tag, ".dout_b0"}, if0.dout_b, e0.b);
    chk1({tag, ".coll0"}, if0.collision, e0.coll);
    chk1({tag, ".coll1"}, if1.collision, e0.coll);
    if (q1.size() >= 2) begin
      e1 = q1.pop_front();
      chk8({tag, ".dout_a1"}, if1.dout_a, e1.a);
      chk8({tag, ".dout_b1"}, if1.dout_b, e1.b);
    end
  endtask

  // Count cycles until init_busy drops while hammering the ports with writes
  task automatic wait_clear(input string tag);
    int n = 0;
    while (n < 40) begin
      drive(1'b1, AW'($urandom_range(0, DEPTH-1)), 8'hEE, 1'b1, AW'(n), 8'hDD, (n == 5));
      if ((n % 4) == 0) begin
        if0.addr_b = if0.addr_a;
        if1.addr_b = if1.addr_a;
      end
      @(posedge clk); #1;
      n++;
      if (!if0.init_busy) break;
      if (n == 3 || n == 9) chk_quiet($sformatf("%s.c%0d", tag, n));
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    chk_int({tag, ".busy_cycles"}, n, DEPTH);
    chk1({tag, ".busy1_done"}, if1.init_busy, 1'b0);
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    q0.delete();
    q1.delete();
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, AW'(i), '0, 1'b0, AW'(DEPTH-1-i), '0, $sformatf("%s%0d", tag, i));
    step(1'b0, '0, '0, 1'b0, '0, '0, {tag, "_drain"});
  endtask

  initial begin
    // wa aa da wb ab db | dout_a dout_b collision (read-first, latency 1)
    tbl[0]  = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd3,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 4'd3,  8'h00, 1'b0, 4'd3,  8'h00, 8'hA5, 8'hA5, 1'b0};
    tbl[2]  = '{1'b1, 4'd7,  8'h11, 1'b0, 4'd0,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 4'd7,  8'h22, 1'b0, 4'd7,  8'h00, 8'h11, 8'h11, 1'b0};
    tbl[4]  = '{1'b0, 4'd7,  8'h00, 1'b0, 4'd7,  8'h00, 8'h22, 8'h22, 1'b0};
    tbl[5]  = '{1'b1, 4'd5,  8'h3C, 1'b1, 4'd5,  8'hC3, 8'h00, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 4'd5,  8'h00, 1'b0, 4'd5,  8'h00, 8'h3C, 8'h3C, 1'b0};
    tbl[7]  = '{1'b1, 4'd9,  8'h5A, 1'b1, 4'd10, 8'hA6, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 4'd10, 8'h00, 1'b0, 4'd9,  8'h00, 8'hA6, 8'h5A, 1'b0};
    tbl[9]  = '{1'b0, 4'd15, 8'h00, 1'b1, 4'd15, 8'hFF, 8'h00, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 4'd15, 8'h00, 1'b0, 4'd15, 8'h00, 8'hFF, 8'hFF, 1'b0};
    tbl[11] = '{1'b0, 4'd3,  8'h00, 1'b1, 4'd3,  8'h77, 8'hA5, 8'hA5, 1'b0};
    tbl[12] = '{1'b0, 4'd3,  8'h00, 1'b0, 4'd0,  8'h00, 8'h77, 8'h00, 1'b0};

    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    reset_n = 1'b1;
    wait_clear("por");
    read_all("por_rd");

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].wa, tbl[i].aa, tbl[i].da, tbl[i].wb, tbl[i].ab, tbl[i].db, $sformatf("v%0d", i));
      chk8($sformatf("tbl%0d.dout_a", i), if0.dout_a, tbl[i].ea);
      chk8($sformatf("tbl%0d.dout_b", i), if0.dout_b, tbl[i].eb);
      chk1($sformatf("tbl%0d.coll", i), if0.collision, tbl[i].ec);
    end
    step(1'b0, 4'd3, '0, 1'b0, 4'd7, '0, "drain0");

    // init_req from READY restarts a full clear pass
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    @(posedge clk); #1;
    chk1("init.busy_start", if0.init_busy, 1'b1);
    wait_clear("init");
    read_all("init_rd");

    // Reset in the middle of READY traffic, right after a collision
    step(1'b1, 4'd2, 8'h99, 1'b0, 4'd2, 8'h00, "pre0");
    step(1'b1, 4'd2, 8'hA5, 1'b1, 4'd2, 8'h5A, "pre_coll");
    reset_n = 1'b0;
    #1;
    chk_quiet("rst_ready");
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_clear("rst_ready_clr");

    // Reset in the middle of a clear pass
    step(1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 8'h00, "pre1");
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_quiet("rst_clear");
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_clear("rst_clear_clr");
    read_all("final_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
